// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   XLEN_DEF      : default datapath / PC width
//   INST_NOP      : instruction word presented when no instruction is queued
//   fetch_entry_t : one prefetch queue entry {pc, inst}
//   fetch_state_e : fetch control state (FAULT only reachable when
//                   FETCH_MISALIGN_FAULT_EN is defined)
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         inst;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the fetch unit's instruction-memory request/response channel, the
// execute redirect, and the decode-side instruction channel.
//   master : the fetch unit (drives requests and the instruction channel)
//   slave  : the environment (memory, execute, decode)
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);

    // Instruction memory request channel
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;

    // Instruction memory response (in order, one-cycle pulse per word)
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    // Taken branch / jump from execute
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    // Decode-side instruction channel
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     Instruction;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output Instruction,
        output inst_pc
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  Instruction,
        input  inst_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch queue of fetch_entry_t, DEPTH entries, registered
// storage (no write-to-read bypass).
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data at the tail (ignored when full and not popping)
//   push_data : entry to write
//   pop       : drop the head (ignored when empty)
//   flush     : empty the queue; wins over push and pop in the same cycle
//   count     : current occupancy
//   head      : entry at the head (meaningful only when count != 0)
// ----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Circular pointer advance for a depth that need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    // Qualify push/pop against occupancy; a full queue still accepts a push
    // when the head leaves in the same cycle
    always_comb begin
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents of free slots are don't-care so no reset needed
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && !rst) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: owns the fetch PC, issues in-order word fetches to instruction
// memory under a credit limit (queued + in-flight <= DEPTH), buffers returned
// words in a prefetch queue and presents {Instruction, inst_pc} to decode.
// A redirect from execute flushes the queue, retargets both the request PC
// and the response PC, and marks every still-outstanding fetch for discard.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : instr_fetch_unit_if.master (imem request/response,
//                 redirect, decode instruction channel)
//   fetch_fault : (only with FETCH_MISALIGN_FAULT_EN) sticky flag raised by a
//                 misaligned redirect target, cleared by an aligned redirect
//
// Build option: define FETCH_MISALIGN_FAULT_EN to trap misaligned redirect
// targets in a FAULT state; otherwise redirect_pc[1:0] is treated as 2'b00.
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
)(
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_FAULT_EN
    ,
    output logic               fetch_fault
`endif
);

    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
    localparam logic [CW:0]     CREDIT_MAX = (CW + 1)'(DEPTH);

    fetch_state_e    state_r,    state_nxt_s;
    logic [XLEN-1:0] fetch_pc_r, fetch_pc_nxt_s;
    logic [XLEN-1:0] rsp_pc_r,   rsp_pc_nxt_s;
    logic [CW-1:0]   inflight_r, inflight_nxt_s;
    logic [CW-1:0]   discard_r,  discard_nxt_s;

    logic [XLEN-1:0] redir_pc_s;
    logic            redir_misalign_s;
    logic            credit_ok_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            rsp_keep_s;
    logic            inst_valid_s;

    logic [CW-1:0]   fifo_count_s;
    fetch_entry_t    fifo_head_s;
    fetch_entry_t    fifo_wdata_s;
    logic            fifo_pop_s;

`ifdef FETCH_MISALIGN_FAULT_EN
    logic            fault_r, fault_nxt_s;

    // Misaligned targets are kept as given and trap into FAULT
    always_comb begin
        redir_pc_s       = bus.redirect_pc;
        redir_misalign_s = (bus.redirect_pc[1:0] != 2'b00);
    end
`else
    logic            redir_lsb_unused_s;

    // Without the fault option the low address bits are simply ignored
    always_comb begin
        redir_pc_s         = {bus.redirect_pc[XLEN-1:2], 2'b00};
        redir_misalign_s   = 1'b0;
        redir_lsb_unused_s = |bus.redirect_pc[1:0];
    end
`endif

    // Request/response qualification and credit accounting
    always_comb begin
        credit_ok_s    = ({1'b0, fifo_count_s} + {1'b0, inflight_r}) < CREDIT_MAX;
        req_valid_s    = !rst && (state_r == FETCH) && !bus.redirect_valid && credit_ok_s;
        req_fire_s     = req_valid_s && bus.imem_req_ready;
        rsp_keep_s     = bus.imem_rsp_valid && (discard_r == {CW{1'b0}});
        inflight_nxt_s = inflight_r + CW'(req_fire_s) - CW'(bus.imem_rsp_valid);
        inst_valid_s   = (fifo_count_s != {CW{1'b0}});
        fifo_pop_s     = inst_valid_s && bus.inst_ready;
        fifo_wdata_s   = '{pc: rsp_pc_r, inst: bus.imem_rsp_data};
    end

    // Next-state: a redirect overrides all normal PC/discard bookkeeping
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        rsp_pc_nxt_s   = rsp_pc_r;
        discard_nxt_s  = discard_r;
        if (bus.redirect_valid) begin
            fetch_pc_nxt_s = redir_pc_s;
            rsp_pc_nxt_s   = redir_pc_s;
            // Everything still outstanding after this cycle's response is stale
            discard_nxt_s  = inflight_nxt_s;
            state_nxt_s    = redir_misalign_s ? FAULT : FETCH;
        end else begin
            if (req_fire_s) begin
                fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (bus.imem_rsp_valid && (discard_r != {CW{1'b0}})) begin
                discard_nxt_s = discard_r - CW'(1'b1);
            end else begin
                discard_nxt_s = discard_r;
            end
            if (rsp_keep_s) begin
                rsp_pc_nxt_s = rsp_pc_r + PC_STEP;
            end else begin
                rsp_pc_nxt_s = rsp_pc_r;
            end
        end
    end

`ifdef FETCH_MISALIGN_FAULT_EN
    // Fault flag follows the alignment of the most recent redirect
    always_comb begin
        if (bus.redirect_valid) begin
            fault_nxt_s = redir_misalign_s;
        end else begin
            fault_nxt_s = fault_r;
        end
    end

    // Sticky fault flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_nxt_s;
        end
    end

    assign fetch_fault = fault_r;
`endif

    // Control and PC state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= FETCH;
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            inflight_r <= {CW{1'b0}};
            discard_r  <= {CW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            rsp_pc_r   <= rsp_pc_nxt_s;
            inflight_r <= inflight_nxt_s;
            discard_r  <= discard_nxt_s;
        end
    end

    // Prefetch queue; the redirect acts as flush and beats any push/pop
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep_s),
        .push_data (fifo_wdata_s),
        .pop       (fifo_pop_s),
        .flush     (bus.redirect_valid),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.inst_valid     = inst_valid_s;
    assign bus.Instruction    = inst_valid_s ? fifo_head_s.inst : INST_NOP;
    assign bus.inst_pc        = inst_valid_s ? fifo_head_s.pc : RESET_PC;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Random-latency in-order memory, random decode back-pressure and random
// redirects, checked every cycle against a queue-level model of the fetch
// stage; directed scenarios pin the model with literal expectations.
// Define FETCH_MISALIGN_FAULT_EN to exercise the fault build.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_MISALIGN_FAULT_EN
    logic fetch_fault;
`endif

    instr_fetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef FETCH_MISALIGN_FAULT_EN
        .fetch_fault (fetch_fault),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int k_ready_pct  = 100;
    int k_iready_pct = 100;
    int k_lat_min    = 1;
    int k_lat_max    = 1;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    mreq_t mq[$];   // memory: accepted requests awaiting response
    ent_t  m_q[$];  // model: prefetch queue contents

    logic [31:0] m_fetch_pc, m_rsp_pc;
    int          m_inflight, m_discard;
    logic        m_fault;

    // per-cycle DUT samples for directed checks
    logic        s_req_valid, s_inst_valid, s_fire, s_pop, s_rsp;
    logic [31:0] s_req_addr, s_inst_pc, s_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc = 32'h0;
        m_rsp_pc   = 32'h0;
        m_inflight = 0;
        m_discard  = 0;
        m_fault    = 1'b0;
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;
        mq.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_instruction", bus.Instruction, NOP);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
`ifdef FETCH_MISALIGN_FAULT_EN
        chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, compare against the model, advance model
    task automatic cycle(input logic redir, input logic [31:0] rpc);
        logic        rsp_v, e_req_valid, e_inst_valid, fire, pop, mis;
        logic [31:0] rsp_d, eff;
        rsp_v = 1'b0;
        rsp_d = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rsp_v = 1'b1;
            rsp_d = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        bus.imem_rsp_valid = rsp_v;
        bus.imem_rsp_data  = rsp_d;
        bus.imem_req_ready = ($urandom_range(99) < k_ready_pct);
        bus.inst_ready     = ($urandom_range(99) < k_iready_pct);
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;

        @(negedge clk);
        e_req_valid  = !m_fault && !redir && ((m_q.size() + m_inflight) < DEPTH);
        e_inst_valid = (m_q.size() != 0);
        chk("req_valid", 32'(bus.imem_req_valid), 32'(e_req_valid));
        if (e_req_valid) chk("req_addr", bus.imem_req_addr, m_fetch_pc);
        chk("inst_valid", 32'(bus.inst_valid), 32'(e_inst_valid));
        if (e_inst_valid) begin
            chk("inst_pc", bus.inst_pc, m_q[0].pc);
            chk("instruction", bus.Instruction, m_q[0].inst);
            chk("inst_vs_mem", bus.Instruction, mem_word(bus.inst_pc));
        end
`ifdef FETCH_MISALIGN_FAULT_EN
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
`endif
        s_req_valid  = bus.imem_req_valid;
        s_req_addr   = bus.imem_req_addr;
        s_inst_valid = bus.inst_valid;
        s_inst_pc    = bus.inst_pc;
        s_inst       = bus.Instruction;
        s_fire       = bus.imem_req_valid && bus.imem_req_ready;
        s_pop        = bus.inst_valid && bus.inst_ready;
        s_rsp        = rsp_v;
        fire         = e_req_valid && bus.imem_req_ready;
        pop          = e_inst_valid && bus.inst_ready;

        @(posedge clk);
        if (s_fire) begin
            mq.push_back('{addr: s_req_addr,
                           due: cyc + int'($urandom_range(k_lat_max, k_lat_min))});
        end
        #1;
        cyc++;

`ifdef FETCH_MISALIGN_FAULT_EN
        eff = rpc;
        mis = (rpc[1:0] != 2'b00);
`else
        eff = {rpc[31:2], 2'b00};
        mis = 1'b0;
`endif
        if (redir) begin
            m_q.delete();
            m_fetch_pc = eff;
            m_rsp_pc   = eff;
            m_inflight = m_inflight - (rsp_v ? 1 : 0);
            m_discard  = m_inflight;
            m_fault    = mis;
        end else begin
            if (fire) m_fetch_pc = m_fetch_pc + 32'd4;
            if (pop) void'(m_q.pop_front());
            if (rsp_v) begin
                if (m_discard > 0) begin
                    m_discard--;
                end else begin
                    m_q.push_back('{pc: m_rsp_pc, inst: rsp_d});
                    m_rsp_pc = m_rsp_pc + 32'd4;
                end
            end
            m_inflight = m_inflight + (fire ? 1 : 0) - (rsp_v ? 1 : 0);
        end
    endtask

    task automatic set_knobs(input int rp, input int ip, input int lmin, input int lmax);
        k_ready_pct  = rp;
        k_iready_pct = ip;
        k_lat_min    = lmin;
        k_lat_max    = lmax;
    endtask

    initial begin
        int          accepted;
        int          found;
        logic [31:0] popped[$];
        logic [31:0] tgt;
        logic [31:0] lsb;

        // ---- streaming with 1-cycle memory ----
        set_knobs(100, 100, 1, 1);
        do_reset();
        cycle(1'b0, 32'h0);
        chk("t1_addr0", s_req_addr, 32'h0);
        chk("t1_valid0", 32'(s_req_valid), 32'd1);
        chk("t1_iv_c0", 32'(s_inst_valid), 32'd0);
        cycle(1'b0, 32'h0);
        chk("t1_addr1", s_req_addr, 32'h4);
        chk("t1_iv_c1", 32'(s_inst_valid), 32'd0);
        cycle(1'b0, 32'h0);
        chk("t1_addr2", s_req_addr, 32'h8);
        chk("t1_iv_c2", 32'(s_inst_valid), 32'd1);
        chk("t1_pc_c2", s_inst_pc, 32'h0);
        chk("t1_inst_c2", s_inst, mem_word(32'h0));
        cycle(1'b0, 32'h0);
        chk("t1_pc_c3", s_inst_pc, 32'h4);
        cycle(1'b0, 32'h0);
        chk("t1_pc_c4", s_inst_pc, 32'h8);

        // ---- decode stalled: credit limit, then drain in order ----
        set_knobs(100, 0, 1, 1);
        do_reset();
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 32'h0);
            if (s_fire) accepted++;
        end
        chk("t2_accepted", 32'(accepted), 32'd4);
        chk("t2_req_blocked", 32'(s_req_valid), 32'd0);
        k_iready_pct = 100;
        popped.delete();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0);
            if (s_pop) popped.push_back(s_inst_pc);
        end
        for (int i = 0; i < 5; i++) begin
            chk("t2_drain_pc", (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF, 32'(i * 4));
        end

        // ---- redirect with stale responses in flight (3-cycle memory) ----
        set_knobs(100, 100, 3, 3);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_0100);
        chk("t3_no_req_on_redirect", 32'(s_req_valid), 32'd0);
        cycle(1'b0, 32'h0);
        chk("t3_flushed", 32'(s_inst_valid), 32'd0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cycle(1'b0, 32'h0);
            if (s_inst_valid) begin
                found = 1;
                chk("t3_first_pc", s_inst_pc, 32'h0000_0100);
            end
        end
        if (found == 0) chk("t3_timeout", 32'd0, 32'd1);

        // ---- redirect coinciding with response and decode handshake ----
        set_knobs(100, 100, 1, 1);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_0040);
        chk("t4_rsp_same_cycle", 32'(s_rsp), 32'd1);
        chk("t4_pop_same_cycle", 32'(s_pop), 32'd1);
        cycle(1'b0, 32'h0);
        chk("t4_flushed", 32'(s_inst_valid), 32'd0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cycle(1'b0, 32'h0);
            if (s_inst_valid) begin
                found = 1;
                chk("t4_first_pc", s_inst_pc, 32'h0000_0040);
            end
        end
        if (found == 0) chk("t4_timeout", 32'd0, 32'd1);

        // ---- memory stall: address holds, redirect retargets it ----
        set_knobs(100, 100, 1, 1);
        do_reset();
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        k_ready_pct = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0);
            chk("t5_stall_addr", s_req_addr, 32'h8);
            chk("t5_stall_valid", 32'(s_req_valid), 32'd1);
        end
        cycle(1'b1, 32'h0000_0300);
        cycle(1'b0, 32'h0);
        chk("t5_retarget_addr", s_req_addr, 32'h0000_0300);
        chk("t5_retarget_valid", 32'(s_req_valid), 32'd1);
        k_ready_pct = 100;

        // ---- misaligned redirect target ----
        set_knobs(100, 100, 1, 2);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_FAULT_EN
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0);
            chk("t6_fault_set", 32'(fetch_fault), 32'd1);
            chk("t6_no_req", 32'(s_req_valid), 32'd0);
        end
        cycle(1'b1, 32'h0000_0200);
        cycle(1'b0, 32'h0);
        chk("t6_fault_clear", 32'(fetch_fault), 32'd0);
        chk("t6_resume_addr", s_req_addr, 32'h0000_0200);
        chk("t6_resume_valid", 32'(s_req_valid), 32'd1);
`else
        cycle(1'b0, 32'h0);
        chk("t6_masked_addr", s_req_addr, 32'h0000_0100);
        chk("t6_masked_valid", 32'(s_req_valid), 32'd1);
`endif

        // ---- randomized traffic ----
        for (int blk = 0; blk < 15; blk++) begin
            set_knobs((blk % 3 == 0) ? 100 : int'($urandom_range(90, 30)),
                      int'($urandom_range(100, 20)), 1, int'($urandom_range(4, 1)));
            if (blk == 7) do_reset();
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(99) < 5) begin
                    tgt = $urandom & 32'hFFFF_FFFC;
                    if ($urandom_range(9) == 0) tgt = 32'hFFFF_FFF0;
                    if ($urandom_range(9) == 0) begin
                        lsb = $urandom_range(3, 1);
                        tgt = tgt | lsb;
                    end
                    cycle(1'b1, tgt);
                end else begin
                    cycle(1'b0, 32'h0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
